// File: rtl/axi_lite_wr_rd_checker.sv
// ---------------------------------------------------------------------------
// axi_lite_wr_rd_checker
//
// Synthesisable AXI4-Lite master that writes a generated pattern to each of
// NUM_REGS slave registers, reads each one back, and compares the two values.
// Errors are counted and the first failing register is recorded. One
// pass/fail result is then reported on the status ports.
//
// Ports
//   ACLK, ARESETN    clock, asynchronous active-low reset
//   start            one-cycle pulse; starts a run from IDLE or DONE
//   busy             a run is in progress
//   done             run finished (normally or by timeout); held until next start
//   pass             valid while done: every register matched with OKAY responses
//   timeout          sticky; a handshake waited TIMEOUT_CYCLES cycles
//   err_count        saturating count of data/response errors
//   first_err_idx    register index of the first error
//   first_err_data   read data of the register that failed first
//   m_axi_*          AXI4-Lite master channels AW, W, B, AR, R
// ---------------------------------------------------------------------------
module axi_lite_wr_rd_checker #(
    parameter int unsigned                    C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                    C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned                    NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]  BASE_ADDR          = '0,
    parameter int unsigned                    ADDR_STRIDE        = 4,
    parameter int unsigned                    PATTERN_MODE       = 0,
    parameter logic [31:0]                    SEED               = 32'h0101FFFF,
    parameter int unsigned                    TIMEOUT_CYCLES     = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              timeout,
    output logic [8:0]                        err_count,
    output logic [7:0]                        first_err_idx,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     first_err_data,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LAST_IDX   = 8'(NUM_REGS - 1);
    // An all-zero LFSR would lock up, so a zero seed starts from 1 instead.
    localparam logic [31:0]   SEED_INIT  = (PATTERN_MODE == 1 && SEED == 32'd0) ? 32'd1 : SEED;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WAIT_B, S_RD, S_WAIT_R, S_DONE, S_FAULT
    } state_t;

    state_t          state;
    logic [7:0]      idx;
    logic [31:0]     pattern;
    logic [AW-1:0]   addr;
    logic [TW-1:0]   timer;
    logic            aw_done;
    logic            w_done;
    logic            capture_rdata;
    logic [DW-1:0]   data_cur;
    logic            aw_hs;
    logic            w_hs;
    logic            ar_hs;
    logic            waiting;
    logic            progress;
    logic            rd_bad;

    // Galois LFSR for x^32+x^22+x^2+x+1 (shift right, tap mask 0x80200003).
    function automatic logic [31:0] next_pattern(input logic [31:0] p);
        if (PATTERN_MODE == 1)
            return p[0] ? ((p >> 1) ^ 32'h80200003) : (p >> 1);
        return p + 32'd1;
    endfunction

    // 64-bit buses carry the inverted pattern in the upper word.
    if (DW == 64) begin : g_dw64
        assign data_cur = {~pattern, pattern};
    end else begin : g_dw32
        assign data_cur = pattern;
    end

    assign m_axi_awaddr = addr;
    assign m_axi_araddr = addr;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wdata  = data_cur;
    assign m_axi_wstrb  = '1;

    assign aw_hs   = m_axi_awvalid && m_axi_awready;
    assign w_hs    = m_axi_wvalid && m_axi_wready;
    assign ar_hs   = m_axi_arvalid && m_axi_arready;
    assign rd_bad  = (m_axi_rresp != 2'b00) || (m_axi_rdata != data_cur);
    assign waiting = (state == S_WR) || (state == S_WAIT_B) || (state == S_RD) || (state == S_WAIT_R);

    // progress: the state's own handshake completes this cycle, so it moves on
    // and its timeout counter must not fire.
    always_comb begin
        progress = 1'b0;
        case (state)
            S_WR:     progress = (aw_done || aw_hs) && (w_done || w_hs);
            S_WAIT_B: progress = m_axi_bvalid;
            S_RD:     progress = ar_hs;
            S_WAIT_R: progress = m_axi_rvalid;
            default:  progress = 1'b0;
        endcase
    end

    // Main controller: sequencing, AXI valids/readies, error bookkeeping and
    // per-state timeout all live in one registered block.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            m_axi_awvalid  <= 1'b0;
            m_axi_wvalid   <= 1'b0;
            m_axi_bready   <= 1'b0;
            m_axi_arvalid  <= 1'b0;
            m_axi_rready   <= 1'b0;
            idx            <= '0;
            pattern        <= '0;
            addr           <= '0;
            timer          <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            capture_rdata  <= 1'b0;
        end else begin
            // Valids drop only after their own handshake, in every state,
            // so a timed-out request is still held until the slave takes it.
            if (aw_hs) m_axi_awvalid <= 1'b0;
            if (w_hs)  m_axi_wvalid  <= 1'b0;
            if (ar_hs) m_axi_arvalid <= 1'b0;

            if (waiting) begin
                if (progress) timer <= '0;
                else          timer <= timer + 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        err_count      <= '0;
                        first_err_idx  <= '0;
                        first_err_data <= '0;
                        capture_rdata  <= 1'b0;
                        idx            <= '0;
                        pattern        <= SEED_INIT;
                        addr           <= BASE_ADDR;
                        timer          <= '0;
                        m_axi_awvalid  <= 1'b1;
                        m_axi_wvalid   <= 1'b1;
                        state          <= S_WR;
                    end
                end
                S_WR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if (progress) begin
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                        m_axi_bready <= 1'b1;
                        state        <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready  <= 1'b0;
                        m_axi_arvalid <= 1'b1;
                        state         <= S_RD;
                        if (m_axi_bresp != 2'b00) begin
                            if (err_count != 9'h1FF) err_count <= err_count + 1'b1;
                            // First error on the write side: its read data is taken later.
                            if (err_count == '0) begin
                                first_err_idx <= idx;
                                capture_rdata <= 1'b1;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (ar_hs) begin
                        m_axi_rready <= 1'b1;
                        state        <= S_WAIT_R;
                    end
                end
                S_WAIT_R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready  <= 1'b0;
                        capture_rdata <= 1'b0;
                        if (capture_rdata) first_err_data <= m_axi_rdata;
                        if (rd_bad) begin
                            if (err_count != 9'h1FF) err_count <= err_count + 1'b1;
                            if (err_count == '0) begin
                                first_err_idx  <= idx;
                                first_err_data <= m_axi_rdata;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (err_count == '0) && !rd_bad;
                            state <= S_DONE;
                        end else begin
                            idx           <= idx + 1'b1;
                            pattern       <= next_pattern(pattern);
                            addr          <= addr + AW'(ADDR_STRIDE);
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= S_WR;
                        end
                    end
                end
                default: begin
                end
            endcase

            // Timeout overrides the state's own next-state; only reset leaves FAULT.
            if (waiting && !progress && (timer == TIMER_LAST)) begin
                state        <= S_FAULT;
                timeout      <= 1'b1;
                done         <= 1'b1;
                pass         <= 1'b0;
                busy         <= 1'b0;
                m_axi_bready <= 1'b0;
                m_axi_rready <= 1'b0;
            end
        end
    end

endmodule
